// File: rtl/obj_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : obj_dma_pkg
// Description : Shared state encoding and source RAM read latency for the
//               object DMA copier.
// Revision    : 1.0 - initial release
// ============================================================================
package obj_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int RD_LATENCY = 1;

endpackage
`default_nettype wire

// File: rtl/obj_dma_counter.sv
`default_nettype none
// ============================================================================
// Module      : obj_dma_counter
// Description : Source word counter with terminal-count flag; stops on the
//               last count instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module obj_dma_counter #(
  parameter int ADDR_WIDTH = 10,
  parameter int XFER_LEN   = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] LAST_CNT = ADDR_WIDTH'(XFER_LEN - 1);

  logic [ADDR_WIDTH-1:0] count_q;
  logic [ADDR_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LAST_CNT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/obj_dma_copier.sv
`default_nettype none
// ============================================================================
// Module      : obj_dma_copier
// Description : Copies XFER_LEN words from a sync-read source RAM to a
//               destination RAM, one word per cycle, stallable via hold.
// Revision    : 1.0 - initial release
// ============================================================================
module obj_dma_copier
  import obj_dma_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int XFER_LEN   = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  hold,
  output logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [DATA_WIDTH-1:0] src_q,
  output logic [ADDR_WIDTH-1:0] dst_addr,
  output logic [DATA_WIDTH-1:0] dst_data,
  output logic                  dst_cen,
  output logic                  dst_we,
  output logic                  busy,
  output logic                  done
);

  if (RD_LATENCY != 1 || XFER_LEN < 1 || XFER_LEN > (1 << ADDR_WIDTH)) begin : g_param_check
    $error("obj_dma_copier: unsupported parameterisation");
  end

  state_e                state_q, state_d;
  logic                  rd_v_q, rd_v_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  skid_v_q, skid_v_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [ADDR_WIDTH-1:0] dst_addr_q, dst_addr_d;
  logic [DATA_WIDTH-1:0] dst_data_q, dst_data_d;
  logic                  dst_wr_q, dst_wr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cnt_clr;
  logic                  cnt_en;
  logic                  cnt_last;
  logic [DATA_WIDTH-1:0] rd_data;

  obj_dma_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .XFER_LEN   (XFER_LEN)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (src_addr),
    .last  (cnt_last)
  );

  // src_q only holds the in-flight word for one cycle; during a stall it is parked here.
  assign rd_data = skid_v_q ? skid_data_q : src_q;

  always_comb begin
    state_d     = state_q;
    rd_v_d      = rd_v_q;
    rd_addr_d   = rd_addr_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    dst_addr_d  = dst_addr_q;
    dst_data_d  = dst_data_q;
    dst_wr_d    = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          busy_d   = 1'b1;
          cnt_clr  = 1'b1;
          rd_v_d   = 1'b0;
          skid_v_d = 1'b0;
        end
      end

      ST_RUN, ST_FLUSH: begin
        if (state_q == ST_FLUSH && !rd_v_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (hold) begin
          if (rd_v_q && !skid_v_q) begin
            skid_v_d    = 1'b1;
            skid_data_d = src_q;
          end
        end else begin
          if (rd_v_q) begin
            dst_wr_d   = 1'b1;
            dst_addr_d = rd_addr_q;
            dst_data_d = rd_data;
          end
          skid_v_d = 1'b0;
          if (state_q == ST_RUN) begin
            rd_v_d    = 1'b1;
            rd_addr_d = src_addr;
            if (cnt_last) begin
              state_d = ST_FLUSH;
            end else begin
              cnt_en = 1'b1;
            end
          end else begin
            rd_v_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_v_q      <= 1'b0;
      rd_addr_q   <= '0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      dst_addr_q  <= '0;
      dst_data_q  <= '0;
      dst_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_v_q      <= rd_v_d;
      rd_addr_q   <= rd_addr_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      dst_addr_q  <= dst_addr_d;
      dst_data_q  <= dst_data_d;
      dst_wr_q    <= dst_wr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign dst_addr = dst_addr_q;
  assign dst_data = dst_data_q;
  assign dst_cen  = dst_wr_q;
  assign dst_we   = dst_wr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_obj_dma_copier.sv
`default_nettype none
// ============================================================================
// Module      : tb_obj_dma_copier
// Description : Directed self-checking bench: three copier instances
//               (512, 1024 and 1 word transfers) over shared RAM models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obj_dma_copier;

  logic       clk = 1'b0;
  logic       rst;
  logic       hold;
  logic       clr;
  logic       start_a, start_b, start_c;
  logic [9:0] src_addr_a, src_addr_b, src_addr_c;
  logic [7:0] src_q_a, src_q_b, src_q_c;
  logic [9:0] dst_addr_a, dst_addr_b, dst_addr_c;
  logic [7:0] dst_data_a, dst_data_b, dst_data_c;
  logic       dst_cen_a, dst_cen_b, dst_cen_c;
  logic       dst_we_a, dst_we_b, dst_we_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  obj_dma_copier #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .XFER_LEN(512)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .hold(hold), .src_addr(src_addr_a), .src_q(src_q_a),
    .dst_addr(dst_addr_a), .dst_data(dst_data_a), .dst_cen(dst_cen_a), .dst_we(dst_we_a),
    .busy(busy_a), .done(done_a));

  obj_dma_copier #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .XFER_LEN(1024)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .hold(hold), .src_addr(src_addr_b), .src_q(src_q_b),
    .dst_addr(dst_addr_b), .dst_data(dst_data_b), .dst_cen(dst_cen_b), .dst_we(dst_we_b),
    .busy(busy_b), .done(done_b));

  obj_dma_copier #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .XFER_LEN(1)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .hold(hold), .src_addr(src_addr_c), .src_q(src_q_c),
    .dst_addr(dst_addr_c), .dst_data(dst_data_c), .dst_cen(dst_cen_c), .dst_we(dst_we_c),
    .busy(busy_c), .done(done_c));

  // Source RAMs: synchronous read of mem[k] = k ^ 8'hA5
  always @(posedge clk) begin
    src_q_a <= src_addr_a[7:0] ^ 8'hA5;
    src_q_b <= src_addr_b[7:0] ^ 8'hA5;
    src_q_c <= src_addr_c[7:0] ^ 8'hA5;
  end

  logic [9:0] m_addr [3];
  logic [7:0] m_data [3];
  logic       m_wr   [3];
  assign m_addr[0] = dst_addr_a;
  assign m_addr[1] = dst_addr_b;
  assign m_addr[2] = dst_addr_c;
  assign m_data[0] = dst_data_a;
  assign m_data[1] = dst_data_b;
  assign m_data[2] = dst_data_c;
  assign m_wr[0]   = dst_cen_a & dst_we_a;
  assign m_wr[1]   = dst_cen_b & dst_we_b;
  assign m_wr[2]   = dst_cen_c & dst_we_c;

  logic [7:0] dst_mem   [3][1024];
  int         wcnt      [3][1024];
  logic [9:0] exp_next  [3];
  int         order_err [3];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 1024; k++) begin
          dst_mem[i][k] <= '0;
          wcnt[i][k]    <= 0;
        end
        exp_next[i]  <= '0;
        order_err[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_wr[i]) begin
          dst_mem[i][m_addr[i]] <= m_data[i];
          wcnt[i][m_addr[i]]    <= wcnt[i][m_addr[i]] + 1;
          if (m_addr[i] != exp_next[i]) order_err[i] <= order_err[i] + 1;
          exp_next[i] <= m_addr[i] + 10'd1;
        end
      end
    end
  end

  function automatic logic [7:0] exp_word(int k);
    return 8'(k) ^ 8'hA5;
  endfunction

  function automatic int count_bad(int sel, int n);
    int bad = 0;
    for (int k = 0; k < n; k++)
      if (dst_mem[sel][k] !== exp_word(k) || wcnt[sel][k] != 1) bad++;
    return bad;
  endfunction

  function automatic logic get_done(int sel);
    case (sel)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic get_busy(int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic get_wr(int sel);
    return m_wr[sel];
  endfunction

  task automatic set_start(input int sel, input logic v);
    start_a = (sel == 0) ? v : 1'b0;
    start_b = (sel == 1) ? v : 1'b0;
    start_c = (sel == 2) ? v : 1'b0;
  endtask

  // Runs one transfer; rel counts cycles after the edge that sampled start.
  task automatic run_xfer(input int sel, input bit hold_on, input int restart_at, input int rst_at,
                          output int lat, output int ndone, output int busy_bad, output int first_wr);
    int rel;
    bit fin;
    lat = -1; ndone = 0; busy_bad = 0; first_wr = -1;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    set_start(sel, 1'b1);
    @(negedge clk);
    rel = 0;
    fin = 1'b0;
    while (!fin && rel < 3000) begin
      if (rst_at > 0 && rel == rst_at + 1) break;
      if (get_done(sel)) begin
        ndone++;
        lat = rel;
        fin = 1'b1;
        if (get_busy(sel)) busy_bad++;
      end else if (!get_busy(sel)) begin
        busy_bad++;
      end
      if (get_wr(sel) && first_wr < 0) first_wr = rel;
      hold = hold_on && (rel inside {5, 6, 7, 100});
      set_start(sel, rel == restart_at);
      rst = (rst_at > 0 && rel == rst_at);
      if (!fin) begin
        @(negedge clk);
        rel++;
      end
    end
    hold = 1'b0;
    set_start(sel, 1'b0);
    if (fin) begin
      repeat (3) begin
        @(negedge clk);
        if (get_done(sel)) ndone++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (src_addr_a !== 10'd0) begin errors++; $display("FAIL reset_src_addr: got %0d want 0", src_addr_a); end
    checks++; if (dst_addr_a !== 10'd0) begin errors++; $display("FAIL reset_dst_addr: got %0d want 0", dst_addr_a); end
    checks++; if (dst_data_a !== 8'd0) begin errors++; $display("FAIL reset_dst_data: got %0d want 0", dst_data_a); end
    checks++; if ({dst_cen_a, dst_we_a} !== 2'b00) begin errors++; $display("FAIL reset_cen_we: got %b want 00", {dst_cen_a, dst_we_a}); end
    checks++; if ({busy_a, busy_b, busy_c} !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b want 000", {busy_a, busy_b, busy_c}); end
    checks++; if ({done_a, done_b, done_c} !== 3'b000) begin errors++; $display("FAIL reset_done: got %b want 000", {done_a, done_b, done_c}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_copy();
    int lat, nd, bb, fw, bad;
    run_xfer(0, 1'b0, -1, 0, lat, nd, bb, fw);
    bad = count_bad(0, 512);
    checks++; if (lat != 514) begin errors++; $display("FAIL copy_latency: got %0d want 514", lat); end
    checks++; if (nd != 1) begin errors++; $display("FAIL copy_done_pulses: got %0d want 1", nd); end
    checks++; if (bb != 0) begin errors++; $display("FAIL copy_busy: got %0d bad cycles want 0", bb); end
    checks++; if (fw != 2) begin errors++; $display("FAIL copy_first_write: got cycle %0d want 2", fw); end
    checks++; if (bad != 0) begin errors++; $display("FAIL copy_data: got %0d bad words want 0", bad); end
    checks++; if (order_err[0] != 0) begin errors++; $display("FAIL copy_order: got %0d want 0", order_err[0]); end
  endtask

  task automatic test_hold();
    int lat, nd, bb, fw, bad;
    run_xfer(0, 1'b1, -1, 0, lat, nd, bb, fw);
    bad = count_bad(0, 512);
    checks++; if (lat != 518) begin errors++; $display("FAIL hold_latency: got %0d want 518", lat); end
    checks++; if (nd != 1) begin errors++; $display("FAIL hold_done_pulses: got %0d want 1", nd); end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_data: got %0d bad words want 0", bad); end
    checks++; if (order_err[0] != 0) begin errors++; $display("FAIL hold_order: got %0d want 0", order_err[0]); end
    checks++; if (bb != 0) begin errors++; $display("FAIL hold_busy: got %0d bad cycles want 0", bb); end
  endtask

  task automatic test_restart();
    int lat, nd, bb, fw, bad;
    run_xfer(0, 1'b0, 200, 0, lat, nd, bb, fw);
    bad = count_bad(0, 512);
    checks++; if (lat != 514) begin errors++; $display("FAIL restart_latency: got %0d want 514", lat); end
    checks++; if (nd != 1) begin errors++; $display("FAIL restart_done_pulses: got %0d want 1", nd); end
    checks++; if (bad != 0) begin errors++; $display("FAIL restart_data: got %0d bad words want 0", bad); end
  endtask

  task automatic test_reset_mid();
    int lat, nd, bb, fw, early, late;
    run_xfer(0, 1'b0, -1, 300, lat, nd, bb, fw);
    checks++; if ({busy_a, done_a, dst_cen_a, dst_we_a} !== 4'b0000) begin errors++; $display("FAIL rstmid_ctrl: got %b want 0000", {busy_a, done_a, dst_cen_a, dst_we_a}); end
    checks++; if ({src_addr_a, dst_addr_a, dst_data_a} !== 28'd0) begin errors++; $display("FAIL rstmid_regs: got src=%0d dst=%0d data=%0d want 0", src_addr_a, dst_addr_a, dst_data_a); end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done_a) nd++;
    end
    early = 0;
    late  = 0;
    for (int k = 0; k < 299; k++) if (wcnt[0][k] != 1 || dst_mem[0][k] !== exp_word(k)) early++;
    for (int k = 299; k < 512; k++) if (wcnt[0][k] != 0) late++;
    checks++; if (nd != 0) begin errors++; $display("FAIL rstmid_done: got %0d pulses want 0", nd); end
    checks++; if (early != 0) begin errors++; $display("FAIL rstmid_early_words: got %0d bad want 0", early); end
    checks++; if (late != 0) begin errors++; $display("FAIL rstmid_late_words: got %0d written want 0", late); end
  endtask

  task automatic test_full_range();
    int lat, nd, bb, fw, bad;
    run_xfer(1, 1'b0, -1, 0, lat, nd, bb, fw);
    bad = count_bad(1, 1024);
    checks++; if (lat != 1026) begin errors++; $display("FAIL full_latency: got %0d want 1026", lat); end
    checks++; if (bad != 0) begin errors++; $display("FAIL full_data: got %0d bad words want 0", bad); end
    checks++; if (wcnt[1][0] != 1) begin errors++; $display("FAIL full_addr0_writes: got %0d want 1", wcnt[1][0]); end
    checks++; if (dst_addr_b !== 10'd1023) begin errors++; $display("FAIL full_final_addr: got %0d want 1023", dst_addr_b); end
    checks++; if (nd != 1) begin errors++; $display("FAIL full_done_pulses: got %0d want 1", nd); end
  endtask

  task automatic test_single();
    int lat, nd, bb, fw;
    run_xfer(2, 1'b0, -1, 0, lat, nd, bb, fw);
    checks++; if (lat != 3) begin errors++; $display("FAIL single_latency: got %0d want 3", lat); end
    checks++; if (wcnt[2][0] != 1 || wcnt[2][1] != 0) begin errors++; $display("FAIL single_writes: got a0=%0d a1=%0d want 1,0", wcnt[2][0], wcnt[2][1]); end
    checks++; if (dst_mem[2][0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", dst_mem[2][0]); end
    checks++; if (nd != 1) begin errors++; $display("FAIL single_done_pulses: got %0d want 1", nd); end
  endtask

  initial begin
    rst     = 1'b1;
    hold    = 1'b0;
    clr     = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    test_reset();
    test_copy();
    test_hold();
    test_restart();
    test_reset_mid();
    test_full_range();
    test_single();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
